// File: rtl/dmem_stall.sv
// Data memory with programmable wait states and byte/half/word accesses.
// Requests are latched in IDLE; busy stalls the requester until the one-cycle done pulse.
module dmem_stall #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             unsigned_ld,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             misalign
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [AW+1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             misalign_q, misalign_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] rd_word, shifted, load_val, wr_lanes;
  logic [NB-1:0]    be;
  logic             bad_align;

  // Address bits above the memory range are ignored, so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^addr[WIDTH-1:AW+2];

  assign idx = addr_q[AW+1:2];

  always_comb begin
    bad_align = 1'b0;
    unique case (size)
      2'b00:   bad_align = 1'b0;
      2'b01:   bad_align = addr[0];
      2'b10:   bad_align = (addr[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
  end

  always_comb begin
    rd_word  = mem[idx];
    shifted  = rd_word >> {addr_q[1:0], 3'b000};
    load_val = rd_word;
    unique case (size_q)
      2'b00:   load_val = uns_q ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                                : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = uns_q ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                                : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: load_val = rd_word;
    endcase
  end

  // Store data is replicated across lanes; byte enables pick which lanes land.
  always_comb begin
    be       = '0;
    wr_lanes = wdata_q;
    unique case (size_q)
      2'b00: begin
        wr_lanes         = {NB{wdata_q[7:0]}};
        be[addr_q[1:0]]  = 1'b1;
      end
      2'b01: begin
        wr_lanes               = {(NB/2){wdata_q[15:0]}};
        be[{addr_q[1], 1'b0}]  = 1'b1;
        be[{addr_q[1], 1'b1}]  = 1'b1;
      end
      2'b10:   be = '1;
      default: be = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      StIdle: begin
        // A held req must not be re-issued in the cycle its result is reported.
        if (req && !done_q && !misalign_q) begin
          if (bad_align) begin
            misalign_d = 1'b1;
          end else begin
            we_d    = we;
            size_d  = size;
            uns_d   = unsigned_ld;
            addr_d  = addr[AW+1:0];
            wdata_d = wdata;
            cnt_d   = 4'(LATENCY);
            state_d = (LATENCY == 0) ? StAccess : StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (!we_q) rdata_d = load_val;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  // Memory contents survive reset; an asserted rst suppresses the write edge.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StAccess && we_q) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  assign rdata    = rdata_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_dmem_stall.sv
// Bench for dmem_stall: a LATENCY=2 and a LATENCY=0 instance sharing data inputs.
module tb_dmem_stall;

  logic        clk, rst;
  logic        req2, req0, we, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata2, rdata0;
  logic        busy2, done2, mis2, busy0, done0, mis0;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  dmem_stall #(.WIDTH(32), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req2), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .rdata(rdata2), .busy(busy2), .done(done2), .misalign(mis2)
  );

  dmem_stall #(.WIDTH(32), .DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .busy(busy0), .done(done0), .misalign(mis0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and holds it until done; cyc=-1 means no done within the budget.
  task automatic run_access(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] d, output int cyc,
                            output logic [31:0] rd, output logic [31:0] bmask);
    bit got;
    bmask = '0;
    cyc   = 0;
    got   = 1'b0;
    @(negedge clk);
    we = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
    if (sel) req0 = 1'b1; else req2 = 1'b1;
    while (cyc < 30 && !got) begin
      @(negedge clk);
      cyc++;
      if (sel ? busy0 : busy2) bmask[cyc] = 1'b1;
      if (sel ? done0 : done2) got = 1'b1;
    end
    rd   = sel ? rdata0 : rdata2;
    req0 = 1'b0;
    req2 = 1'b0;
    if (!got) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({rdata2, busy2, done2, mis2} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h/%b%b%b required 0/000", rdata2, busy2, done2, mis2);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    int cyc; logic [31:0] rd, bm, exp;
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, cyc, rd, bm);
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL word_store_latency: got %0d required 4", cyc); end
    checks++;
    if (bm !== 32'h0000_000E) begin
      failures++; $display("FAIL word_store_busy: got %h required 0000000e", bm);
    end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL store_keeps_rdata: got %h required 0", rd); end
    exp_q.push_back(32'hDEADBEEF);
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, cyc, rd, bm);
    exp = exp_q.pop_front();
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL word_load_latency: got %0d required 4", cyc); end
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL word_load: got %h required %h", rd, exp); end
  endtask

  task automatic test_byte_lane();
    int cyc; logic [31:0] rd, bm, exp;
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, cyc, rd, bm);
    run_access(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hAAAAAA7F, cyc, rd, bm);
    exp_q.push_back(32'h00007F00);
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, cyc, rd, bm);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL byte_store_lane: got %h required %h", rd, exp); end
    // A store after the load must leave rdata alone.
    run_access(0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h11, cyc, rd, bm);
    checks++;
    if (rd !== 32'h00007F00) begin
      failures++; $display("FAIL store_holds_rdata: got %h required 00007f00", rd);
    end
  endtask

  task automatic test_extend();
    int cyc; logic [31:0] rd, bm, exp;
    logic [1:0]  sz_t [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    logic        u_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a_t  [5] = '{32'h32, 32'h32, 32'h33, 32'h33, 32'h32};
    logic [31:0] e_t  [5] = '{32'hFFFF80F0, 32'h000080F0, 32'hFFFFFF80, 32'h00000080,
                              32'hFFFFFFF0};
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h80F00000, cyc, rd, bm);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(e_t[i]);
      run_access(0, 1'b0, sz_t[i], u_t[i], a_t[i], 32'h0, cyc, rd, bm);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
        failures++; $display("FAIL extend_%0d: got %h required %h", i, rd, exp);
      end
    end
  endtask

  task automatic test_misalign();
    int cyc; logic [31:0] rd, bm, exp;
    logic        w_t  [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  sz_t [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] a_t  [3] = '{32'h06, 32'h01, 32'h04};
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h01020304, cyc, rd, bm);
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h00, 32'hA5A5A5A5, cyc, rd, bm);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      we = w_t[i]; size = sz_t[i]; addr = a_t[i]; wdata = 32'hFFFFFFFF; req2 = 1'b1;
      @(negedge clk);
      checks++;
      if ({mis2, busy2, done2} !== 3'b100) begin
        failures++; $display("FAIL misalign_pulse_%0d: got %b required 100", i, {mis2, busy2, done2});
      end
      req2 = 1'b0;
      @(negedge clk);
      checks++;
      if ({mis2, busy2, done2} !== 3'b000) begin
        failures++; $display("FAIL misalign_clear_%0d: got %b required 000", i, {mis2, busy2, done2});
      end
    end
    exp_q.push_back(32'h01020304);
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, cyc, rd, bm);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL misalign_untouched_4: got %h required %h", rd, exp); end
    exp_q.push_back(32'hA5A5A5A5);
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, cyc, rd, bm);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL misalign_untouched_0: got %h required %h", rd, exp); end
  endtask

  task automatic test_latency0();
    int cyc; logic [31:0] rd, bm;
    run_access(1, 1'b1, 2'b10, 1'b0, 32'h08, 32'h12345678, cyc, rd, bm);
    checks++;
    if (cyc !== 2 || bm !== 32'h2) begin
      failures++; $display("FAIL lat0_store: got cyc=%0d busy=%h required 2/00000002", cyc, bm);
    end
    @(negedge clk);
    we = 1'b0; size = 2'b10; addr = 32'h08; req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || rdata0 !== 32'h12345678) begin
      failures++; $display("FAIL lat0_load: got done=%b rdata=%h required 1/12345678", done0, rdata0);
    end
    @(negedge clk);
    checks++;
    if ({busy0, done0} !== 2'b00) begin
      failures++; $display("FAIL lat0_no_reissue: got busy/done=%b required 00", {busy0, done0});
    end
    req0 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_wrap();
    int cyc; logic [31:0] rd, bm, exp;
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, cyc, rd, bm);
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, cyc, rd, bm);
    @(negedge clk);
    we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h55555555; req2 = 1'b1;
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b1) begin failures++; $display("FAIL abort_in_wait: got busy=%b required 1", busy2); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rdata2, busy2, done2, mis2} !== 35'd0) begin
      failures++;
      $display("FAIL async_reset: got %h/%b%b%b required 0/000", rdata2, busy2, done2, mis2);
    end
    req2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h11223344);
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, cyc, rd, bm);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL abort_no_write: got %h required %h", rd, exp); end
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, cyc, rd, bm);
    exp_q.push_back(32'hCAFEF00D);
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, cyc, rd, bm);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL addr_wrap: got %h required %h", rd, exp); end
  endtask

  initial begin
    req2 = 1'b0; req0 = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    addr = '0; wdata = '0;
    test_reset();
    test_word();
    test_byte_lane();
    test_extend();
    test_misalign();
    test_latency0();
    test_reset_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
